// File: rtl/pipe_alu.sv
// Pipelined ALU with valid/ready handshake; single-cycle ops have latency 1 and full throughput, the output register stalls under OUT_READY=0.
// Define PIPE_ALU_MUL_EN to turn opcode 111 into an N-cycle iterative unsigned multiply (replaces SRL).
module pipe_alu #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   OP,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] C,
  output logic         OV,
  output logic         Z
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state, next_state;
  logic         accept;
  logic         is_mul;
  logic         mul_done;
  logic [N-1:0] mul_c;
  logic [N-1:0] sum, diff;
  logic [N-1:0] alu_c;
  logic         alu_ov;

  assign accept = IN_VALID && IN_READY;
  assign sum    = A + B;
  assign diff   = A - B;

  always_comb begin
    alu_c  = '0;
    alu_ov = 1'b0;
    unique case (OP)
      OP_ADD: begin
        alu_c  = sum;
        alu_ov = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
      end
      OP_AND: alu_c = A & B;
      OP_OR:  alu_c = A | B;
      OP_NOR: alu_c = ~(A | B);
      OP_SUB: begin
        alu_c  = diff;
        alu_ov = (A[N-1] != B[N-1]) && (diff[N-1] != A[N-1]);
      end
      OP_SLT: alu_c = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL: alu_c = A << B[SW-1:0];
`ifndef PIPE_ALU_MUL_EN
      OP_SRL: alu_c = A >> B[SW-1:0];
`endif
      default: alu_c = '0;
    endcase
  end

`ifdef PIPE_ALU_MUL_EN
  logic [SW-1:0] cnt;
  logic [N-1:0]  acc, mcand, mplier, acc_next;

  assign is_mul   = (OP == 3'b111);
  assign mul_done = (state == BUSY) && (cnt == SW'(N - 1));
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  // The final partial product is folded in on the done edge, so mul_c is acc_next.
  assign mul_c    = acc_next;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (accept && is_mul) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= A;
      mplier <= B;
    end else if (state == BUSY) begin
      cnt    <= cnt + 1'b1;
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_c    = '0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept && is_mul) next_state = BUSY;
      BUSY:    if (mul_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    IN_READY = RSTN && (state == IDLE) && (!OUT_VALID || OUT_READY);
  end

  // Accepting a multiply with a pending result only happens alongside its transfer, so OUT_VALID clears.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      OUT_VALID <= 1'b0;
      C         <= '0;
      OV        <= 1'b0;
      Z         <= 1'b0;
    end else if (accept && !is_mul) begin
      OUT_VALID <= 1'b1;
      C         <= alu_c;
      OV        <= alu_ov;
      Z         <= (alu_c == '0);
    end else if (mul_done) begin
      OUT_VALID <= 1'b1;
      C         <= mul_c;
      OV        <= 1'b0;
      Z         <= (mul_c == '0);
    end else if (OUT_VALID && OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_alu.sv
// Randomized bench for pipe_alu (N=32) against a cycle-level transaction model, plus directed literal cases.
module tb_pipe_alu;

  localparam int N = 32;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b1;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [N-1:0]  A = '0;
  logic [N-1:0]  B = '0;
  logic [2:0]    OP = 3'b000;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [N-1:0]  C;
  logic          OV;
  logic          Z;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_alu #(.N(N)) dut (
    .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .OP(OP), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .C(C), .OV(OV), .Z(Z)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  // Reference semantics in plain integer arithmetic.
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                  output logic [31:0] c, output logic ov);
    longint sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    p  = '0;
    ov = 1'b0;
    c  = '0;
    case (op)
      3'd0: begin r = sa + sb; c = r[31:0]; ov = (r > MAX_S) || (r < MIN_S); end
      3'd1: c = a & b;
      3'd2: c = a | b;
      3'd3: c = ~(a | b);
      3'd4: begin r = sa - sb; c = r[31:0]; ov = (r > MAX_S) || (r < MIN_S); end
      3'd5: c = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: c = a << (b % 32);
`ifdef PIPE_ALU_MUL_EN
      3'd7: begin p = {32'd0, a} * {32'd0, b}; c = p[31:0]; end
`else
      3'd7: c = a >> (b % 32);
`endif
      default: c = '0;
    endcase
  endfunction

  // Transaction model state, advanced once per clock at the falling edge.
  bit          m_valid = 0;
  logic [31:0] m_c = '0;
  bit          m_ov = 0, m_z = 0;
  int          m_busy = 0;
  logic [31:0] m_pend = '0;

  always @(negedge CLK) begin
    bit exp_ready;
    logic [31:0] rc;
    logic rov;
    if (!RSTN) begin
      m_valid = 0; m_c = '0; m_ov = 0; m_z = 0; m_busy = 0;
      check("model_reset", {28'd0, OUT_VALID, IN_READY, OV, Z, C}, 64'd0);
    end else begin
      exp_ready = (m_busy == 0) && (!m_valid || OUT_READY);
      check("model", {28'd0, OUT_VALID, IN_READY, OV, Z, C},
            {28'd0, m_valid, exp_ready, m_ov, m_z, m_c});
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1; m_c = m_pend; m_ov = 0; m_z = (m_pend == 0);
        end
      end else if (IN_VALID && exp_ready) begin
        ref_alu(A, B, OP, rc, rov);
`ifdef PIPE_ALU_MUL_EN
        if (OP == 3'd7) begin
          m_busy = N; m_pend = rc; m_valid = 0;
        end else begin
          m_valid = 1; m_c = rc; m_ov = rov; m_z = (rc == 0);
        end
`else
        m_valid = 1; m_c = rc; m_ov = rov; m_z = (rc == 0);
`endif
      end else if (m_valid && OUT_READY) begin
        m_valid = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    repeat (n) cyc();
  endtask

  task automatic op_once(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    A = a; B = b; OP = op; IN_VALID = 1'b1;
    cyc();
    IN_VALID = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rc;
    logic rov;
    int bad;

    ref_alu(32'h7FFF_FFFF, 32'd1, 3'd0, rc, rov);
    check("model_add_ov", {31'd0, rov, rc}, {31'd0, 1'b1, 32'h8000_0000});
    ref_alu(32'hFFFF_FFFF, 32'd1, 3'd5, rc, rov);
    check("model_slt", {32'd0, rc}, 64'd1);
    ref_alu(32'h8000_0000, 32'd1, 3'd4, rc, rov);
    check("model_sub_ov", {31'd0, rov, rc}, {31'd0, 1'b1, 32'h7FFF_FFFF});

    #2 RSTN = 1'b0;
    #1;
    check("reset_out", {29'd0, OUT_VALID, OV, Z, C}, 64'd0);
    check("reset_in_ready", {63'd0, IN_READY}, 64'd0);
    repeat (3) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    OUT_READY = 1'b1;
    #1;
    check("release_in_ready", {63'd0, IN_READY}, 64'd1);
    cyc();

    op_once(32'h7FFF_FFFF, 32'd1, 3'd0);
    check("add_ovf", {30'd0, OUT_VALID, OV, Z, C}, {30'd0, 1'b1, 1'b1, 1'b0, 32'h8000_0000});
    op_once(32'd5, 32'd5, 3'd4);
    check("sub_zero", {31'd0, OV, Z, C}, {31'd0, 1'b0, 1'b1, 32'd0});
    op_once(32'hFFFF_FFFF, 32'd1, 3'd5);
    check("slt_neg", {32'd0, C}, 64'd1);
    op_once(32'd1, 32'h24, 3'd6);
    check("sll_mask", {32'd0, C}, 64'h10);
    op_once(32'd0, 32'd0, 3'd3);
    check("nor_zero", {32'd0, C}, 64'hFFFF_FFFF);

    idle(2);
    OUT_READY = 1'b0;
    op_once(32'h1000, 32'h234, 3'd0);
    for (int k = 0; k < 3; k++) begin
      check("bp_hold", {30'd0, OUT_VALID, IN_READY, C}, {30'd0, 1'b1, 1'b0, 32'h1234});
      cyc();
    end
    OUT_READY = 1'b1;
    A = 32'd2; B = 32'd3; OP = 3'd0; IN_VALID = 1'b1;
    #1;
    check("bp_ready_comb", {63'd0, IN_READY}, 64'd1);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    check("bp_swap", {31'd0, OUT_VALID, C}, {31'd0, 1'b1, 32'd5});

    idle(2);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      A = i; B = 32'd100; OP = 3'd0; IN_VALID = 1'b1;
      cyc();
      if (OUT_VALID !== 1'b1 || C !== 32'(i + 100)) bad++;
    end
    IN_VALID = 1'b0;
    check("b2b_8_adds", 64'(bad), 64'd0);

    idle(2);
    for (int i = 0; i < 1500; i++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 3) != 0);
      OP = 3'($urandom_range(0, 7));
      A = pick();
      B = pick();
      cyc();
    end

    idle(N + 3);
    OUT_READY = 1'b0;
    op_once(32'h7FFF_FFFF, 32'd1, 3'd0);
    check("pre_reset_pending", {31'd0, OUT_VALID, OV, C}, {31'd0, 1'b1, 1'b1, 32'h8000_0000});
    RSTN = 1'b0;
    #1;
    check("midreset_out", {28'd0, OUT_VALID, IN_READY, OV, Z, C}, 64'd0);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    OUT_READY = 1'b1;
    #1;
    check("midreset_release", {62'd0, IN_READY, OUT_VALID}, 64'd2);
    cyc();

`ifdef PIPE_ALU_MUL_EN
    op_once(32'h0001_0000, 32'h0001_0001, 3'd7);
    bad = 0;
    for (int k = 0; k < N; k++) begin
      if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0) bad++;
      cyc();
    end
    check("mul_busy_window", 64'(bad), 64'd0);
    check("mul_result", {30'd0, OUT_VALID, OV, C}, {30'd0, 1'b1, 1'b0, 32'h0001_0000});
    idle(2);
    op_once(32'd7, 32'd9, 3'd7);
    repeat (9) cyc();
    RSTN = 1'b0;
    #1;
    check("mul_abort_reset", {62'd0, OUT_VALID, IN_READY}, 64'd0);
    cyc();
    RSTN = 1'b1;
    bad = 0;
    for (int k = 0; k < N + 5; k++) begin
      if (OUT_VALID !== 1'b0) bad++;
      cyc();
    end
    check("mul_abort_no_result", 64'(bad), 64'd0);
    check("mul_abort_idle", {63'd0, IN_READY}, 64'd1);
`else
    op_once(32'h8000_0000, 32'd31, 3'd7);
    check("srl_msb", {31'd0, OUT_VALID, C}, {31'd0, 1'b1, 32'd1});
`endif

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
